uart_rx: RTL and testbench
==========================

# uart_rx

Serial receive half of the UART: recovers 8N1 frames from the asynchronous `serial_rx` pin and presents each byte on a valid/ready holding register. Ownership of a byte passes to the consumer on handshake. It pairs with the transmit shift path and uses the same bit-period convention: one bit lasts `CLOCKS_PER_BIT` clock cycles. It sits between the board RX pin and whichever core logic consumes host bytes. The block detects framing errors and overruns, and reports each as a one-cycle pulse.

## Interface
- `CLOCKS_PER_BIT`, default 104 (1 MHz / 9600 baud): clock cycles per serial bit. Legal range is 4 and up. `HALF` = `CLOCKS_PER_BIT / 2`, truncated.
- `clock`  in  1  sole clock. All logic is clocked on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `serial_rx`  in  1  asynchronous line. Idles high.
- `rx_byte`  out  8  most recently delivered byte. Stable while `rx_valid` is high.
- `rx_valid`  out  1  a byte is held and waiting for the consumer.
- `rx_ready`  in  1  the consumer accepts the byte on any edge where `rx_valid && rx_ready`.
- `frame_error`  out  1  one-cycle pulse when a stop bit is sampled as 0.
- `overrun`  out  1  one-cycle pulse when a completed byte is dropped because the holding register is full.
- `busy`  out  1  high while in START, DATA or STOP.

## Operation
- Synchronizer: two flops on `serial_rx`, both reset to 1. All decisions use the synchronized level `rxs`.
- Counters:
  - bit-timing counter, wide enough for `CLOCKS_PER_BIT-1`
  - 3-bit bit index
  - 8-bit shift register, filled LSB first: each new bit enters at bit 7 and the register shifts right.
- States:
  - WAIT_HIGH (reset state): go to IDLE on the first edge where `rxs==1`.
  - IDLE: if `rxs==0`, go to START and clear the counter.
  - START: count up. When the counter reaches `HALF-1`, sample `rxs`.
    - If the sample is 1, it was a glitch: go to IDLE.
    - If the sample is 0, go to DATA with counter = 0 and index = 0.
  - DATA: when the counter reaches `CLOCKS_PER_BIT-1`, sample `rxs` into the shift register, clear the counter and increment the index. After the 8th sample (index 7), go to STOP.
  - STOP: when the counter reaches `CLOCKS_PER_BIT-1`, sample `rxs`.
    - If the sample is 1, deliver the byte and go to IDLE.
    - If the sample is 0, pulse `frame_error`, discard the byte and go to WAIT_HIGH, so a break does not restart reception.
- Delivery:
  - If `rx_valid==0`, or `rx_ready==1` on the same edge: load `rx_byte` and set `rx_valid`. `overrun` stays 0.
  - Otherwise: drop the new byte, pulse `overrun`, and leave `rx_byte` and `rx_valid` unchanged.
- Handshake: `rx_valid` clears on the edge after `rx_valid && rx_ready`, unless a delivery happens on that same edge, in which case it stays high with the new byte. `rx_ready` while `rx_valid==0` has no effect.
- Reset (any time, including mid-frame):
  - state = WAIT_HIGH
  - `rx_byte`=0x00, `rx_valid`=0, `frame_error`=0, `overrun`=0, `busy`=0
  - counters and shift register = 0
  - the partial frame is discarded. If the line is low at reset release, no start is accepted until `rxs` has been seen high.

## Timing
- `rxs` lags the pin by 2 clocks.
- E0 = the edge at which IDLE sees `rxs==0`.
- Sample points:
  - start bit: E0+`HALF`
  - data bit k (k = 0..7): E0+`HALF`+(k+1)·`CLOCKS_PER_BIT`
  - stop bit: E0+`HALF`+9·`CLOCKS_PER_BIT`
- `rx_valid`, `rx_byte`, `frame_error` and `overrun` update at the stop-sample edge and are visible in the following cycle. Error pulses last exactly 1 cycle.
- IDLE is re-entered at the stop-sample edge, so a start bit arriving immediately after the stop bit (full-rate back-to-back frames) is accepted.
- `busy` rises at E0 and falls at the glitch-reject edge or the stop-sample edge.
- Tolerated baud mismatch is about ±4% (sampling at mid-bit). Sub-`HALF` glitches on an idle line are rejected.

## Test plan
- `CLOCKS_PER_BIT`=8, `rx_ready`=1, send 0xA5 8N1 → `rx_valid` high for 1 cycle after edge E0+76, `rx_byte`=0xA5, no error pulses, `busy` high E0..E0+76.
- Line low for 3 cycles, then high (glitch) → START rejects at E0+4. `rx_valid`, `frame_error` and `overrun` stay 0, and the block is back in IDLE.
- Send 0x3C with stop bit 0, then hold the line low for 20 bit times, then high, then send 0x42 → one `frame_error` pulse, no `rx_valid` for 0x3C, no start during the low period, 0x42 received correctly.
- `rx_ready`=0, send 0x11 then 0x22 back-to-back → `rx_valid` set with 0x11. At the second stop sample, `overrun` pulses once and `rx_byte` stays 0x11. Raising `rx_ready` for 1 cycle clears `rx_valid`.
- `rx_valid`=1 holding 0x11, with `rx_ready` asserted exactly on the stop-sample edge of 0x33 → no `overrun`, `rx_valid` stays 1, `rx_byte`=0x33.
- Assert `reset` for 1 cycle during data bit 3 while the line is low → all outputs 0, no delivery. After the line idles high, a following 0x5A frame is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//
// Serial receive half of the UART. Recovers 8N1 frames from the asynchronous
// serial_rx pin, samples each bit at mid-period and hands every completed byte
// to the consumer through a valid/ready holding register. Framing errors and
// overruns are reported as single-cycle pulses.
//
// Parameters
//   CLOCKS_PER_BIT  clock cycles per serial bit (4 and up)
//
// Ports
//   clock        in   sole clock, rising edge
//   reset        in   synchronous, active-high reset
//   serial_rx    in   asynchronous receive line, idles high
//   rx_byte      out  [7:0] most recently delivered byte
//   rx_valid     out  a byte is held for the consumer
//   rx_ready     in   consumer accepts the held byte when rx_valid is high
//   frame_error  out  one-cycle pulse: stop bit sampled low
//   overrun      out  one-cycle pulse: completed byte dropped, holder full
//   busy         out  a frame is being received (START, DATA or STOP)
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int CLOCKS_PER_BIT = 104
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       serial_rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_error,
  output logic       overrun,
  output logic       busy
);

  localparam int HALF  = CLOCKS_PER_BIT / 2;
  localparam int CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] S_WAIT_HIGH = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_DATA      = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;

  logic [1:0]       sync;
  logic             rxs;
  logic [2:0]       state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;

  // Two-flop synchronizer. Both stages reset to the idle (high) line level so
  // reset never manufactures a falling edge.
  // NOTE: every flop here is written with <= so all registers update from the
  // values they held before the edge; blocking = would let later statements
  // see half-updated state and break the shift chain.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], serial_rx};
    end
  end

  assign rxs  = sync[1];
  assign busy = (state == S_START) || (state == S_DATA) || (state == S_STOP);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_WAIT_HIGH;
      bit_cnt     <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      rx_byte     <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      // Pulses default low; a later assignment in this block wins.
      frame_error <= 1'b0;
      overrun     <= 1'b0;

      // Consumer handshake. A delivery on the same edge (below) overrides
      // this clear, so rx_valid stays high with the new byte.
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        // Only leave after the line has actually been seen high, so a held
        // break or a line low at reset release cannot start a frame.
        S_WAIT_HIGH: begin
          if (rxs) begin
            state <= S_IDLE;
          end
        end

        S_IDLE: begin
          if (!rxs) begin
            state   <= S_START;
            bit_cnt <= '0;
          end
        end

        // Re-check the start bit at its midpoint; a high level there means
        // the falling edge was a glitch.
        S_START: begin
          if (bit_cnt == CNT_MID) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            state   <= rxs ? S_IDLE : S_DATA;
          end else begin
            bit_cnt <= bit_cnt + CNT_ONE;
          end
        end

        // From the start-bit midpoint, every full bit period lands at the
        // middle of the next data bit. LSB arrives first, so bits enter at
        // the top and shift down.
        S_DATA: begin
          if (bit_cnt == CNT_LAST) begin
            bit_cnt   <= '0;
            shift_reg <= {rxs, shift_reg[7:1]};
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_ONE;
          end
        end

        // Returning to IDLE right at the stop-bit midpoint leaves half a bit
        // of margin to catch a back-to-back start edge.
        S_STOP: begin
          if (bit_cnt == CNT_LAST) begin
            bit_cnt <= '0;
            if (rxs) begin
              state <= S_IDLE;
              if (!rx_valid || rx_ready) begin
                rx_byte  <= shift_reg;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_error <= 1'b1;
              state       <= S_WAIT_HIGH;
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_ONE;
          end
        end

        default: begin
          state <= S_WAIT_HIGH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//
// Self-checking bench for uart_rx with CLOCKS_PER_BIT = 8 (HALF = 4).
// Expected bytes are queued when a frame is driven and compared whenever the
// DUT hands a byte over (rx_valid && rx_ready). A vector table covers plain
// frames and a framing error; directed sequences cover exact timing, glitch
// rejection, break handling, overrun, same-edge accept/deliver and reset.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_rx;

  localparam int CPB = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       serial_rx;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_error;
  logic       overrun;
  logic       busy;

  int n_tests   = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int fe_cycles = 0;
  int ov_cycles = 0;

  logic [7:0] sb[$];

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       exp_deliver;
    int         exp_fe;
  } vec_t;

  vec_t vecs[7];

  uart_rx #(.CLOCKS_PER_BIT(CPB)) dut (
    .clock       (clock),
    .reset       (reset),
    .serial_rx   (serial_rx),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_error (frame_error),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Watches the handshake and the error pulses at the falling edge, where
  // everything driven after the rising edge has settled.
  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (rx_valid && rx_ready) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_unexpected: got byte %02h, expected no delivery", rx_byte);
          end else begin
            e = sb.pop_front();
            check("sb_byte", rx_byte, e);
          end
        end
        if (frame_error) fe_cycles++;
        if (overrun)     ov_cycles++;
      end
    end
  endtask

  // All stimulus tasks are entered and left 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    serial_rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      serial_rx = d[i];
      idle(CPB);
    end
    serial_rx = stop;
    idle(CPB);
  endtask

  initial begin
    int p;
    int e0;
    int fe0;
    int ov0;
    int n;
    logic exp_busy;
    logic exp_valid;

    vecs[0] = '{8'h00, 1'b1, 1'b1, 0};
    vecs[1] = '{8'hFF, 1'b1, 1'b1, 0};
    vecs[2] = '{8'h55, 1'b1, 1'b1, 0};
    vecs[3] = '{8'h80, 1'b1, 1'b1, 0};
    vecs[4] = '{8'h01, 1'b1, 1'b1, 0};
    vecs[5] = '{8'h7E, 1'b0, 1'b0, 1};
    vecs[6] = '{8'hC3, 1'b1, 1'b1, 0};

    serial_rx = 1'b1;
    rx_ready  = 1'b1;
    reset     = 1'b1;
    fork
      monitor();
    join_none

    // Reset state
    idle(3);
    check("rst_valid", rx_valid, 0);
    check("rst_byte", rx_byte, 0);
    check("rst_fe", frame_error, 0);
    check("rst_ov", overrun, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    idle(2 * CPB);

    // Vector table, consumer always ready
    for (int i = 0; i < 7; i++) begin
      fe0 = fe_cycles;
      if (vecs[i].exp_deliver) sb.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop_bit);
      serial_rx = 1'b1;
      idle(2 * CPB);
      check("vec_fe", fe_cycles - fe0, vecs[i].exp_fe);
      check("vec_drained", sb.size(), 0);
      check("vec_busy", busy, 0);
    end

    // Exact timing of a 0xA5 frame: E0 three edges after the pin falls,
    // stop sample and delivery at E0+76.
    fe0 = fe_cycles;
    ov0 = ov_cycles;
    p   = cyc;
    e0  = p + 3;
    sb.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int i = 0; i < 90; i++) begin
          @(negedge clock);
          n         = cyc;
          exp_busy  = (n >= e0) && (n <= e0 + 75);
          exp_valid = (n == e0 + 76);
          check("t1_busy", busy, exp_busy);
          check("t1_valid", rx_valid, exp_valid);
          if (exp_valid) check("t1_byte", rx_byte, 8'hA5);
        end
      end
    join
    check("t1_no_fe", fe_cycles - fe0, 0);
    check("t1_no_ov", ov_cycles - ov0, 0);
    check("t1_drained", sb.size(), 0);
    idle(CPB);

    // Glitch: 3 low cycles, rejected at E0+4
    fe0 = fe_cycles;
    ov0 = ov_cycles;
    serial_rx = 1'b0;
    idle(3);
    serial_rx = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("t2_busy_before_reject", busy, 1);
    @(posedge clock);
    @(negedge clock);
    check("t2_busy_after_reject", busy, 0);
    idle(2 * CPB);
    check("t2_valid", rx_valid, 0);
    check("t2_no_fe", fe_cycles - fe0, 0);
    check("t2_no_ov", ov_cycles - ov0, 0);

    // Framing error followed by a 20-bit break, then a good frame
    fe0 = fe_cycles;
    send_frame(8'h3C, 1'b0);
    for (int i = 0; i < 20; i++) begin
      idle(CPB);
      check("t3_no_start", busy, 0);
    end
    check("t3_no_valid", rx_valid, 0);
    check("t3_one_fe", fe_cycles - fe0, 1);
    serial_rx = 1'b1;
    idle(2 * CPB);
    sb.push_back(8'h42);
    send_frame(8'h42, 1'b1);
    idle(2 * CPB);
    check("t3_drained", sb.size(), 0);
    check("t3_fe_total", fe_cycles - fe0, 1);

    // Overrun: consumer stalled across two back-to-back frames
    rx_ready = 1'b0;
    ov0      = ov_cycles;
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(4);
    check("t4_ov_once", ov_cycles - ov0, 1);
    check("t4_valid", rx_valid, 1);
    check("t4_byte_kept", rx_byte, 8'h11);
    rx_ready = 1'b1;
    idle(1);
    rx_ready = 1'b0;
    check("t4_valid_cleared", rx_valid, 0);
    check("t4_drained", sb.size(), 0);
    idle(CPB);

    // Accept on the very edge a new byte is delivered: no overrun
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    idle(CPB);
    check("t5_holding", rx_valid, 1);
    ov0 = ov_cycles;
    sb.push_back(8'h33);
    p = cyc;
    fork
      send_frame(8'h33, 1'b1);
      begin
        idle(78);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
      end
    join
    check("t5_valid", rx_valid, 1);
    check("t5_byte", rx_byte, 8'h33);
    check("t5_no_ov", ov_cycles - ov0, 0);
    check("t5_stop_edge", cyc - p, 80);
    rx_ready = 1'b1;
    idle(1);
    rx_ready = 1'b0;
    check("t5_drained", sb.size(), 0);
    check("t5_valid_cleared", rx_valid, 0);
    idle(CPB);

    // Reset pulse during data bit 3 with the line low
    rx_ready  = 1'b1;
    serial_rx = 1'b0;
    idle(4 * CPB + 4);
    check("t6_busy_mid_frame", busy, 1);
    reset = 1'b1;
    idle(1);
    check("t6_rst_valid", rx_valid, 0);
    check("t6_rst_byte", rx_byte, 0);
    check("t6_rst_fe", frame_error, 0);
    check("t6_rst_ov", overrun, 0);
    check("t6_rst_busy", busy, 0);
    reset     = 1'b0;
    serial_rx = 1'b1;
    idle(2 * CPB);
    check("t6_idle_busy", busy, 0);
    check("t6_no_delivery", rx_valid, 0);
    sb.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    idle(2 * CPB);
    check("t6_drained", sb.size(), 0);
    check("t6_byte", rx_byte, 8'h5A);

    check("total_fe", fe_cycles, 2);
    check("total_ov", ov_cycles, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
